spi_master_ctrl: RTL and testbench

Single-transaction SPI master (mode 0: CPOL=0, CPHA=0) launched by a one-cycle `start` pulse. It sits directly downstream of the push-button debouncer, which produces a clean one-cycle press pulse.
- On each press it shifts out one DATA_W-bit word on MOSI, MSB first, and captures DATA_W bits from MISO.
- When the transfer ends it presents the captured word and raises a one-cycle `done`.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sclk_gen.sv | 56 +++++
 rtl/spi_master_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode
// constants and the default geometry used by the top and the clock generator.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_DATA_W  = 16;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the SPI master.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   load_i          first SHIFT edge: drive sclk to its active level now
//   en_i            high while the master is in SHIFT
//   clr_i           leaving SHIFT: return to idle level, clear divider
//   sclk_o          registered SPI clock level
//   rise_tick_o     sclk goes 0->1 at the coming edge
//   fall_tick_o     sclk goes 1->0 at the coming edge
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int                DIV_W   = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic             sclk_q;
  logic             wrap;

  // Down counter: a toggle happens when it sits at zero, then it reloads.
  assign wrap        = en_i && (cnt_q == '0);
  // The load edge is itself the first rising edge of the transfer.
  assign rise_tick_o = load_i || (wrap && (sclk_q == SPI_CPOL));
  assign fall_tick_o = wrap && (sclk_q != SPI_CPOL);
  assign sclk_o      = sclk_q;

  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else if (load_i) begin
      cnt_q  <= DIV_MAX;
      sclk_q <= ~SPI_CPOL;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_q  <= DIV_MAX;
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-transaction SPI master, mode 0, launched by a one-cycle start pulse.
// Shifts DATA_W bits out on mosi (MSB first) while capturing miso, then
// presents the captured word with a one-cycle done.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   start           launch pulse, ignored while busy
//   tx_data         word to send, sampled on the accepting edge
//   busy            state is not IDLE
//   done            one-cycle end-of-transfer pulse
//   rx_data         last captured word, updated with done
//   sclk, cs_n      SPI clock (idle low) and active-low chip select
//   mosi, miso      serial data out / in
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int               DIV_W   = $clog2(CLK_DIV + 1);
  localparam int               BIT_W   = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LST = BIT_W'(DATA_W - 1);

  spi_state_e        state_q;
  logic [DIV_W-1:0]  ph_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              done_q;

  logic ph_last;
  logic sclk_load;
  logic sclk_en;
  logic shift_end;
  logic rise_tick;
  logic fall_tick;

  assign ph_last   = (ph_q == DIV_MAX);
  assign sclk_load = (state_q == ST_SETUP) && ph_last;
  assign sclk_en   = (state_q == ST_SHIFT);
  // All DATA_W falls seen: the slot of the next rise closes SHIFT instead.
  assign shift_end = sclk_en && rise_tick && (bit_q == BIT_ALL);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clock       (clock),
    .reset       (reset),
    .load_i      (sclk_load),
    .en_i        (sclk_en),
    .clr_i       (shift_end),
    .sclk_o      (sclk),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (rise_tick && !shift_end)
        rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tx_sh_q <= tx_data;
            mosi_q  <= tx_data[DATA_W-1];
            cs_n_q  <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_last) begin
            ph_q    <= '0;
            state_q <= ST_SHIFT;
          end else begin
            ph_q <= ph_q + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (fall_tick) begin
            bit_q <= bit_q + BIT_W'(1);
            // The final fall leaves the LSB on mosi.
            if (bit_q != BIT_LST) begin
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              mosi_q  <= tx_sh_q[DATA_W-2];
            end
          end
          if (shift_end)
            state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ph_last) begin
            ph_q    <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            rx_q    <= rx_sh_q;
            state_q <= ST_DONE;
          end else begin
            ph_q <= ph_q + DIV_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign rx_data = rx_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

  localparam int CDA = 2, DWA = 8;
  localparam int CDB = 1, DWB = 2;

  typedef struct {
    int         c;     // cycle counter value on the negedge start was driven
    logic [7:0] rx;
    logic [7:0] mo;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // ---- DUT A: CLK_DIV=2, DATA_W=8
  logic           start_a = 1'b0;
  logic [DWA-1:0] tx_a    = '0;
  logic           busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
  logic [DWA-1:0] rx_a;
  logic           loop_a  = 1'b1;

  // Mode-0 slave: first bit valid when cs falls, next bit after each sclk fall.
  logic [7:0] sl_val   = 8'h00;
  int         sl_falls = 0;
  int         sl_base  = 0;
  logic [2:0] sl_idx;
  always @(negedge sclk_a) sl_falls <= sl_falls + 1;
  always @(negedge cs_a)   sl_base  <= sl_falls;
  assign sl_idx = 3'(7 - (sl_falls - sl_base));
  assign miso_a = loop_a ? mosi_a : sl_val[sl_idx];

  spi_master_ctrl #(.CLK_DIV(CDA), .DATA_W(DWA)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a),
    .cs_n(cs_a), .mosi(mosi_a), .miso(miso_a)
  );

  // ---- DUT B: CLK_DIV=1, DATA_W=2, loopback
  logic           start_b = 1'b0;
  logic [DWB-1:0] tx_b    = '0;
  logic           busy_b, done_b, sclk_b, cs_b, mosi_b;
  logic [DWB-1:0] rx_b;

  spi_master_ctrl #(.CLK_DIV(CDB), .DATA_W(DWB)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b),
    .cs_n(cs_b), .mosi(mosi_b), .miso(mosi_b)
  );

  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- monitor A: tracks the bus during a frame, scores it on done
  logic cs_pa = 1'b1, sclk_pa = 1'b0;
  int   fall_ca = -1, first_ra = -1, rises_a = 0, done_cnt_a = 0;
  logic [7:0] mbits_a = '0;

  always @(negedge clock) begin
    exp_t e;
    if (!sclk_pa && sclk_a && !cs_a) begin
      if (first_ra < 0) first_ra <= cyc;
      rises_a <= rises_a + 1;
      mbits_a <= {mbits_a[6:0], mosi_a};
    end
    if (cs_pa && !cs_a) begin
      fall_ca  <= cyc;
      first_ra <= -1;
      rises_a  <= 0;
      mbits_a  <= '0;
    end
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      chk("a_done_expected", sb_a.size() > 0, 1);
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        chk("a_rx_data",    rx_a,     e.rx);
        chk("a_done_cycle", cyc,      e.c + 37);
        chk("a_cs_fall",    fall_ca,  e.c + 1);
        chk("a_first_rise", first_ra, e.c + 3);
        chk("a_rise_count", rises_a,  8);
        chk("a_mosi_bits",  mbits_a,  e.mo);
      end
    end
    cs_pa   <= cs_a;
    sclk_pa <= sclk_a;
  end

  // ---- monitor B
  logic sclk_pb = 1'b0, cs_pb = 1'b1;
  int   rises_b = 0, run_b = 0;
  logic hi_bad_b = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (sclk_b) run_b <= run_b + 1;
    else begin
      if (run_b > 1) hi_bad_b <= 1'b1;
      run_b <= 0;
    end
    if (!sclk_pb && sclk_b) rises_b <= rises_b + 1;
    if (cs_pb && !cs_b) begin
      rises_b  <= 0;
      hi_bad_b <= 1'b0;
    end
    if (done_b) begin
      chk("b_done_expected", sb_b.size() > 0, 1);
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        chk("b_rx_data",    rx_b,     e.rx[1:0]);
        chk("b_done_cycle", cyc,      e.c + 7);
        chk("b_rise_count", rises_b,  2);
        chk("b_sclk_high1", hi_bad_b, 0);
      end
    end
    sclk_pb <= sclk_b;
    cs_pb   <= cs_b;
  end

  // ---- stimulus helpers
  task automatic go_a(input logic [7:0] d, input logic [7:0] erx, input bit push,
                      output int c);
    @(negedge clock);
    c       = cyc;
    start_a = 1'b1;
    tx_a    = d;
    if (push) sb_a.push_back('{c, erx, d});
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic wait_until(input int t);
    int g = 0;
    while (cyc < t && g < 2000) begin
      @(negedge clock);
      g++;
    end
  endtask

  task automatic wait_done_a(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (done_a) seen = 1'b1;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    int c, n0;
    bit seen;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_cs_n",  cs_a,   1);
    chk("rst_sclk",  sclk_a, 0);
    chk("rst_mosi",  mosi_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_rx",    rx_a,   0);
    chk("rst_b_cs",  cs_b,   1);
    chk("rst_b_bsy", busy_b, 0);
    reset = 1'b0;
    @(negedge clock);

    // basic loopback transfer
    loop_a = 1'b1;
    go_a(8'hA5, 8'hA5, 1'b1, c);
    wait_done_a("basic_done_seen");

    // capture from slave model
    loop_a = 1'b0;
    sl_val = 8'h3C;
    go_a(8'hFF, 8'h3C, 1'b1, c);
    wait_done_a("capture_done_seen");
    repeat (2) @(negedge clock);

    // start while busy, tx_data changes mid-flight, start in the DONE cycle
    loop_a = 1'b1;
    n0 = done_cnt_a;
    go_a(8'h5A, 8'h5A, 1'b1, c);
    wait_until(c + 10);
    start_a = 1'b1; tx_a = 8'hFF;
    @(negedge clock);
    start_a = 1'b0;
    wait_until(c + 37);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk("busy_ign_cs_38",   cs_a,   1);
    chk("busy_ign_busy_38", busy_a, 0);
    @(negedge clock);
    chk("busy_ign_cs_39",   cs_a,   1);
    chk("busy_ign_one_done", done_cnt_a, n0 + 1);

    // back-to-back
    go_a(8'hC3, 8'hC3, 1'b1, c);
    wait_done_a("b2b_first_done");
    go_a(8'h3C, 8'h3C, 1'b1, c);
    wait_done_a("b2b_second_done");
    repeat (2) @(negedge clock);

    // reset mid-transfer
    go_a(8'hF0, 8'h00, 1'b0, c);
    wait_until(c + 20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_cs_n", cs_a,   1);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_mosi", mosi_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_rx",   rx_a,   0);
    chk("abort_done", done_a, 0);
    n0 = done_cnt_a;
    repeat (45) @(negedge clock);
    chk("abort_no_done", done_cnt_a, n0);
    go_a(8'h96, 8'h96, 1'b1, c);
    wait_done_a("after_abort_done");

    // parameter corner on DUT B
    @(negedge clock);
    c       = cyc;
    start_b = 1'b1;
    tx_b    = 2'b10;
    sb_b.push_back('{c, 8'h02, 8'h02});
    @(negedge clock);
    start_b = 1'b0;
    tx_b    = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (done_b) seen = 1'b1;
    end
    chk("b_done_seen", seen, 1);
    repeat (3) @(negedge clock);

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
